apb_regfile_completer: RTL

- Parametrised APB completer: a bank of NUM_REGS scratch registers with byte-strobe writes, programmable wait states and error responses.
- Next generation of the single-register dummy peripheral used behind the SCCB bridge. Serves as the standard bridge/interconnect test target and as a general scratchpad.
- pready/prdata/pslverr are registered, so bridge timing can be stressed with zero or many wait states.

---
 rtl/apb_regfile_completer.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/apb_regfile_completer.sv
// apb_regfile_completer
//   APB completer exposing NUM_REGS scratch registers with byte-strobe
//   writes, a programmable number of wait states and error responses for
//   misaligned / out-of-range accesses. pready, prdata and pslverr are all
//   registered outputs.
//
//   Optional build macro: APB_REGFILE_WAIT_JITTER_EN
//     When defined, a 16-bit LFSR adds 0..3 extra wait states per transfer.
//
// Ports
//   pclk, preset_n   clock, asynchronous active-low reset
//   psel, penable    APB select / enable
//   pwrite           1 = write, 0 = read
//   paddr            byte address
//   pwdata, pstrb    write data and byte write strobes
//   pready           transfer complete (one cycle)
//   prdata           read data (zero for writes and errors)
//   pslverr          error response

// One storage word: each byte lane loads independently under its strobe.
module apb_regfile_word #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                    pclk,
    input  logic                    preset_n,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic [DATA_WIDTH-1:0]   q
);
    localparam int NUM_LANES = DATA_WIDTH / 8;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        always_ff @(posedge pclk or negedge preset_n) begin
            if (!preset_n)
                q[8*l +: 8] <= RESET_VALUE[8*l +: 8];
            else if (wr_en && wstrb[l])
                q[8*l +: 8] <= wdata[8*l +: 8];
        end
    end
endmodule

module apb_regfile_completer #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                    pclk,
    input  logic                    preset_n,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic                    pready,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pslverr
);
    localparam int                  NUM_LANES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] BYTES   = ADDR_WIDTH'(NUM_LANES);
    localparam int                  IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    // Wide enough for the largest effective wait (WAIT_STATES + 3 jitter).
    localparam int                  CNT_W     = $clog2(WAIT_STATES + 4);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t                              state, state_nxt;
    logic   [CNT_W-1:0]                  cnt, cnt_nxt, eff_wait;
    logic   [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;

    // Latched request attributes from the setup phase.
    logic                                lat_write, lat_err;
    logic   [IDX_W-1:0]                  lat_idx;

    // Attributes of the transfer currently being completed.
    logic                                cur_write, cur_err;
    logic   [IDX_W-1:0]                  cur_idx;
    logic                                latch_en, done_enter;

    // ---------------------------------------------------------------
    // Address decode. The extra MSB of the subtraction is the borrow,
    // i.e. paddr below BASE_ADDR.
    // ---------------------------------------------------------------
    logic                  dec_under, dec_err;
    logic [ADDR_WIDTH-1:0] dec_off, dec_quot;
    logic [IDX_W-1:0]      dec_idx;

    always_comb begin
        {dec_under, dec_off} = {1'b0, paddr} - {1'b0, BASE_ADDR};
        dec_quot = dec_off / BYTES;
        dec_idx  = IDX_W'(dec_quot);
        dec_err  = dec_under || ((dec_off % BYTES) != '0) ||
                   (dec_quot >= ADDR_WIDTH'(NUM_REGS));
    end

    // ---------------------------------------------------------------
    // Effective wait count for the transfer being accepted.
    // ---------------------------------------------------------------
`ifdef APB_REGFILE_WAIT_JITTER_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR, taps 16,14,13,11; free-running every cycle.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) lfsr <= 16'hACE1;
        else           lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign eff_wait = CNT_W'(WAIT_STATES) + CNT_W'(lfsr[1:0]);
`else
    assign eff_wait = CNT_W'(WAIT_STATES);
`endif

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        latch_en   = 1'b0;
        done_enter = 1'b0;
        cur_write  = lat_write;
        cur_err    = lat_err;
        cur_idx    = lat_idx;
        case (state)
            S_IDLE: begin
                // A lone penable without a setup phase is ignored.
                if (psel && !penable) begin
                    latch_en  = 1'b1;
                    // Zero-wait transfers complete on the setup edge itself,
                    // so the live decode feeds the completion path.
                    cur_write = pwrite;
                    cur_err   = dec_err;
                    cur_idx   = dec_idx;
                    if (eff_wait == '0) begin
                        state_nxt  = S_DONE;
                        done_enter = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = eff_wait - CNT_W'(1);
                    end
                end
            end
            S_WAIT: begin
                if (!psel) begin
                    // Requester abandoned the transfer: no write, no response.
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    state_nxt  = S_DONE;
                    done_enter = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
            lat_idx   <= '0;
        end else if (latch_en) begin
            lat_write <= pwrite;
            lat_err   <= dec_err;
            lat_idx   <= dec_idx;
        end
    end

    // ---------------------------------------------------------------
    // Register bank
    // ---------------------------------------------------------------
    logic commit_wr;
    assign commit_wr = done_enter && cur_write && !cur_err;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        apb_regfile_word #(
            .DATA_WIDTH  (DATA_WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_word (
            .pclk     (pclk),
            .preset_n (preset_n),
            .wr_en    (commit_wr && (cur_idx == IDX_W'(r))),
            .wdata    (pwdata),
            .wstrb    (pstrb),
            .q        (regs[r])
        );
    end

    // ---------------------------------------------------------------
    // Registered response: set on the DONE entry edge, cleared on exit.
    // ---------------------------------------------------------------
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end else if (done_enter) begin
            pready  <= 1'b1;
            pslverr <= cur_err;
            prdata  <= (!cur_write && !cur_err) ? regs[cur_idx] : '0;
        end else if (state == S_DONE) begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end
    end
endmodule
